// File: rtl/serial_pattern_matcher.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_matcher
// Brief    : Serial bit-stream matcher against a loadable 1..MAX_LEN bit pattern,
//            with Mealy/Moore output, overlap control and a saturating hit count.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_matcher #(
    parameter int                   MAX_LEN     = 8,
    parameter int                   LEN_W       = 4,
    parameter int                   CNT_W       = 4,
    parameter logic [MAX_LEN-1:0]   DEFAULT_PAT = 8'b0000_1101,
    parameter int                   DEFAULT_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               mode,
    input  logic               overlap,
    output logic               match,
    output logic [CNT_W-1:0]   count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    // Only MAX_LEN-1 past bits are kept: the newest bit always comes from x.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_match_q;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fill_ok;
    logic               w_eq;
    logic               w_hit;
    logic [LEN_W-1:0]   w_len_clamped;

    assign w_window = {r_hist, x};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_fill_ok = (int'(r_fill) + 1) >= int'(r_len);
    assign w_eq      = ((w_window ^ r_pat) & w_mask) == '0;
    assign w_hit     = x_valid & ~load & ~reset & w_fill_ok & w_eq;

    always_comb begin
        w_len_clamped = len_in;
        if (len_in == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (int'(len_in) > MAX_LEN) begin
            w_len_clamped = LEN_W'(MAX_LEN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat     <= DEFAULT_PAT;
            r_len     <= LEN_W'(DEFAULT_LEN);
            r_hist    <= '0;
            r_fill    <= '0;
            r_match_q <= 1'b0;
            r_count   <= '0;
        end else if (load) begin
            r_pat     <= pattern_in;
            r_len     <= w_len_clamped;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match_q <= 1'b0;
            r_count   <= '0;
        end else begin
            r_match_q <= w_hit;
            if (w_hit && (r_count != c_cnt_max)) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (x_valid) begin
                // Non-overlapping mode forgets the whole history on a hit.
                if (w_hit && !overlap) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_window[MAX_LEN-2:0];
                    if (int'(r_fill) < MAX_LEN) begin
                        r_fill <= r_fill + LEN_W'(1);
                    end
                end
            end
        end
    end

    assign match = mode ? w_hit : r_match_q;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_matcher
// Brief    : Scoreboard bench for serial_pattern_matcher with a bit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_matcher;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 4;

    logic               clk;
    logic               reset;
    logic               x;
    logic               x_valid;
    logic               load;
    logic [MAX_LEN-1:0] pattern_in;
    logic [LEN_W-1:0]   len_in;
    logic               mode;
    logic               overlap;
    logic               match;
    logic [CNT_W-1:0]   count;

    serial_pattern_matcher #(
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W),
        .CNT_W      (CNT_W),
        .DEFAULT_PAT(8'b0000_1101),
        .DEFAULT_LEN(4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .x_valid   (x_valid),
        .load      (load),
        .pattern_in(pattern_in),
        .len_in    (len_in),
        .mode      (mode),
        .overlap   (overlap),
        .match     (match),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             m;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_n    = 0;

    // Reference model: bits accepted since the last reset/load/non-overlap hit.
    int               m_fresh[$];
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    logic             m_prev_hit;
    int               m_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_fresh.delete();
        m_pat      = 8'b0000_1101;
        m_len      = 4;
        m_prev_hit = 1'b0;
        m_count    = 0;
    endtask

    task automatic cyc(input logic v, input logic b, input logic ld = 1'b0, input logic rs = 1'b0);
        logic e_hit;
        logic bit_k;
        exp_t e;
        @(posedge clk);
        #1;
        x_valid = v;
        x       = b;
        load    = ld;
        reset   = rs;
        cyc_n++;

        e_hit = v && !ld && !rs && ((m_fresh.size() + 1) >= m_len);
        if (e_hit) begin
            for (int k = 0; k < m_len; k++) begin
                bit_k = (k == 0) ? b : logic'(m_fresh[m_fresh.size() - k]);
                if (bit_k != m_pat[k]) e_hit = 1'b0;
            end
        end

        if (!rs) begin
            e.m = mode ? e_hit : m_prev_hit;
            e.c = CNT_W'(m_count);
            sb.push_back(e);
        end

        if (rs) begin
            model_reset();
        end else if (ld) begin
            m_pat      = pattern_in;
            m_len      = (len_in == 0) ? 1 : ((int'(len_in) > MAX_LEN) ? MAX_LEN : int'(len_in));
            m_fresh.delete();
            m_prev_hit = 1'b0;
            m_count    = 0;
        end else begin
            m_prev_hit = e_hit;
            if (e_hit && m_count < (1 << CNT_W) - 1) m_count++;
            if (v) begin
                if (e_hit && !overlap) begin
                    m_fresh.delete();
                end else begin
                    m_fresh.push_back(int'(b));
                    if (m_fresh.size() > MAX_LEN) void'(m_fresh.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk($sformatf("match@%0d", cyc_n), 32'(match), 32'(mon_e.m));
            chk($sformatf("count@%0d", cyc_n), 32'(count), 32'(mon_e.c));
        end
    end

    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i]);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Idle two cycles, then compare the hit count against a hand-derived value.
    task automatic settle_count(input string tag, input int want);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk(tag, 32'(count), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        x          = 1'b0;
        x_valid    = 1'b0;
        load       = 1'b0;
        pattern_in = 8'b0000_1101;
        len_in     = 4'd4;
        mode       = 1'b0;
        overlap    = 1'b1;
        model_reset();

        do_reset();
        cyc(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("reset_match", 32'(match), 32'd0);
        chk("reset_count", 32'(count), 32'd0);

        // Moore, overlapping: 1101101 hits on bits 4 and 7
        send(32'b1101101, 7);
        settle_count("moore_ovl_count", 2);

        // Moore, non-overlapping: bit 7 has only 3 fresh bits
        do_reset();
        overlap = 1'b0;
        send(32'b1101101, 7);
        settle_count("moore_novl_count", 1);

        // Mealy, overlapping: match visible while bit 4 is presented
        do_reset();
        overlap = 1'b1;
        mode    = 1'b1;
        send(32'b1101, 4);
        @(negedge clk);
        #1;
        chk("mealy_bit4", 32'(match), 32'd1);
        send(32'b101, 3);
        settle_count("mealy_ovl_count", 2);

        // Length-8 alternating pattern, counter saturation
        mode       = 1'b0;
        pattern_in = 8'b1010_1010;
        len_in     = 4'd8;
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
        settle_count("saturate_count", 15);

        // Valid gap inside a match still completes it
        do_reset();
        send(32'b110, 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        settle_count("gap_count", 1);

        // Load during the gap discards the partial match
        do_reset();
        pattern_in = 8'b0000_1101;
        len_in     = 4'd4;
        send(32'b110, 3);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        settle_count("gap_load_count", 0);

        // Mid-stream reset discards the partial match
        do_reset();
        send(32'b110, 3);
        do_reset();
        cyc(1'b1, 1'b1);
        settle_count("midreset_count", 0);
        send(32'b1101, 4);
        settle_count("after_reset_count", 1);

        // len_in=0 behaves as length 1: every accepted 1 is a hit
        pattern_in = 8'b0000_0001;
        len_in     = 4'd0;
        cyc(1'b0, 1'b0, 1'b1);
        mode = 1'b1;
        send(32'b1011, 4);
        settle_count("len0_count", 3);

        // len_in above MAX_LEN clamps to MAX_LEN
        mode       = 1'b0;
        pattern_in = 8'b1101_0011;
        len_in     = 4'd15;
        cyc(1'b0, 1'b0, 1'b1);
        send(32'b1101_0011, 8);
        settle_count("len_clamp_count", 1);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
